demux_1to4: RTL and testbench
=============================

Name: demux_1to4

Overview:
- Registered 1-to-4 demultiplexer: routes a WIDTH-bit input word to one of four outputs selected by a 2-bit select.
- Used as a fan-out stage in front of four downstream consumers; unselected outputs are driven to zero.
- Single clock domain; outputs are registered with 1-cycle latency.

Parameters:
- WIDTH, 1, bit width of the data input and of each output.
- CNT_W, 8, width of the per-output route counters; used only when DEMUX_ROUTE_CNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- in  input  WIDTH  data word to route.
- select  input  2  destination index (00→out0, 01→out1, 10→out2, 11→out3).
- en  input  1  route enable; when low the outputs hold.
- out0  output  WIDTH  destination 0, registered.
- out1  output  WIDTH  destination 1, registered.
- out2  output  WIDTH  destination 2, registered.
- out3  output  WIDTH  destination 3, registered.
- sel_onehot  output  4  registered one-hot of the last enabled select; bit i corresponds to out i.

Behaviour:
- Reset (rst=1, any time, independent of clk):
  - out0..out3 go to 0 immediately.
  - sel_onehot goes to 4'b0000.
  - Counters, if present, go to 0.
- Reset deassertion: takes effect at the next rising clk edge; the first edge with rst=0 performs a normal update.
- Rising clk edge with rst=0 and en=1:
  - out[select] <= in.
  - The other three outputs <= 0.
  - sel_onehot <= 1 << select.
- Rising clk edge with rst=0 and en=0: all outputs and sel_onehot hold their previous values.
- Latency: exactly 1 clock from in/select/en sampled to the outputs.
- At most one output is nonzero at any time after the first enabled edge; the outputs are mutually exclusive.
- Select changing every cycle: each edge routes independently, with no extra latency or glitch cycle.
- in=0 with en=1: the selected output becomes 0 and the others are cleared. sel_onehot still updates, so it is the authoritative record of the route.
- X/Z on select with en=1 is not supported. The default branch clears all outputs and sets sel_onehot to 0.
- The module has no combinational path from inputs to outputs.

Optional Feature:
- Macro: DEMUX_ROUTE_CNT_EN.
- Defined: adds outputs cnt0..cnt3, each CNT_W bits.
  - cnt[i] increments on each rising edge where rst=0, en=1 and select=i.
  - Counters saturate at all-ones and do not wrap.
  - Asynchronous reset to 0.
  - Counters update on the same edge as the outputs.
- Not defined: no counter ports or logic exist, and the port list is exactly as above.

Decomposition:
- Package demux_pkg holds:
  - NUM_OUT=4 and SEL_W=2.
  - typedef enum logic [1:0] sel_e {SEL_OUT0, SEL_OUT1, SEL_OUT2, SEL_OUT3}.
  - Function onehot4(sel_e) returning logic [3:0].
- One natural sub-module: sat_counter, a parameterised CNT_W saturating incrementer with async active-high reset.
  - Instantiated four times under DEMUX_ROUTE_CNT_EN.
- No other sub-modules.

Test Plan:
- Reset: assert rst mid-cycle with out1=1 → all outputs and sel_onehot read 0 before the next clk edge; they stay 0 while rst=1.
- Sweep: WIDTH=1, en=1, in=1, select 00,01,10,11 on successive edges → after each edge exactly out0, out1, out2, out3 =1 in turn (others 0); sel_onehot 0001, 0010, 0100, 1000.
- Hold: after routing in=1 to out2, drive en=0 with select=00, in=0 for 3 edges → out2 stays 1 and sel_onehot stays 0100.
- Latency/data: WIDTH=8, in=8'hA5, select=11, en=1 → out3=8'hA5 exactly one edge later and out0..out2=0; next edge in=8'h3C, select=00 → out0=8'h3C, out3=0.
- Zero data: in=0, select=01, en=1 → all outputs 0 and sel_onehot=0010.
- Counters (DEMUX_ROUTE_CNT_EN, CNT_W=2): 5 enabled edges with select=10 → cnt2 reads 1,2,3,3,3; cnt0, cnt1 and cnt3 stay 0; rst clears all counters.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-4 demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_OUT = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [1:0] {
        SEL_OUT0 = 2'd0,
        SEL_OUT1 = 2'd1,
        SEL_OUT2 = 2'd2,
        SEL_OUT3 = 2'd3
    } sel_e;

    // An unknown select matches no item and yields all zeros.
    function automatic logic [3:0] onehot4(sel_e sel);
        logic [3:0] oh;
        oh = 4'b0000;
        case (sel)
            SEL_OUT0: oh = 4'b0001;
            SEL_OUT1: oh = 4'b0010;
            SEL_OUT2: oh = 4'b0100;
            SEL_OUT3: oh = 4'b1000;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer; unselected outputs are cleared on each enabled edge.
// Define DEMUX_ROUTE_CNT_EN to add saturating per-output route counters cnt0..cnt3.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       select,
    input  logic             en,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
`ifdef DEMUX_ROUTE_CNT_EN
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
`endif
    output logic [3:0]       sel_onehot
);

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    sel_e             sel;
    logic [WIDTH-1:0] out0_d, out1_d, out2_d, out3_d;
    logic [WIDTH-1:0] out0_q, out1_q, out2_q, out3_q;
    logic [3:0]       onehot_d, onehot_q;

    assign sel = sel_e'(select);

    always_comb begin
        out0_d   = '0;
        out1_d   = '0;
        out2_d   = '0;
        out3_d   = '0;
        onehot_d = onehot4(sel);
        case (sel)
            SEL_OUT0: out0_d = in;
            SEL_OUT1: out1_d = in;
            SEL_OUT2: out2_d = in;
            SEL_OUT3: out3_d = in;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_q   <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            out3_q   <= '0;
            onehot_q <= '0;
        end else if (en) begin
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            out3_q   <= out3_d;
            onehot_q <= onehot_d;
        end
    end

    assign out0       = out0_q;
    assign out1       = out1_q;
    assign out2       = out2_q;
    assign out3       = out3_q;
    assign sel_onehot = onehot_q;

`ifdef DEMUX_ROUTE_CNT_EN
    // Increment strobes reuse the decoded select so counters track the data routing.
    sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (en && onehot_d[0]),
        .count_o (cnt0)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (en && onehot_d[1]),
        .count_o (cnt1)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (en && onehot_d[2]),
        .count_o (cnt2)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt3 (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (en && onehot_d[3]),
        .count_o (cnt3)
    );
`endif

endmodule

// File: tb/tb_demux_1to4.sv
// Directed self-checking bench for demux_1to4 (WIDTH=8, CNT_W=2).
module tb_demux_1to4;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic [1:0]       select;
    logic             en;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic [3:0]       sel_onehot;
`ifdef DEMUX_ROUTE_CNT_EN
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

    int checks = 0;
    int errors = 0;

    demux_1to4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (din),
        .select     (select),
        .en         (en),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
`ifdef DEMUX_ROUTE_CNT_EN
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt3       (cnt3),
`endif
        .sel_onehot (sel_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {out3, out2, out1, out0};
    endfunction

    task automatic drive(input logic e, input logic [1:0] s, input logic [WIDTH-1:0] d);
        @(negedge clk);
        en     = e;
        select = s;
        din    = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        select = 2'b00;
        din    = '0;
        #1;
        check_eq("reset_outs", outs(), 32'h0);
        check_eq("reset_onehot", {28'h0, sel_onehot}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sweep: in=1 to each output in turn.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'h01);
            step();
            check_eq($sformatf("sweep_outs_%0d", i), outs(), 32'h1 << (8 * i));
            check_eq($sformatf("sweep_onehot_%0d", i), {28'h0, sel_onehot}, 32'h1 << i);
        end

        // Hold: route to out2, then three disabled edges.
        drive(1'b1, 2'b10, 8'h01);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 8'h00);
            step();
            check_eq($sformatf("hold_outs_%0d", i), outs(), 32'h0001_0000);
            check_eq($sformatf("hold_onehot_%0d", i), {28'h0, sel_onehot}, 32'h4);
        end

        // Latency: no change before the edge, new value right after it.
        drive(1'b1, 2'b11, 8'hA5);
        #1;
        check_eq("lat_pre_edge", outs(), 32'h0001_0000);
        step();
        check_eq("lat_out3", outs(), 32'hA500_0000);
        check_eq("lat_onehot", {28'h0, sel_onehot}, 32'h8);
        drive(1'b1, 2'b00, 8'h3C);
        step();
        check_eq("data_out0", outs(), 32'h0000_003C);
        check_eq("data_onehot", {28'h0, sel_onehot}, 32'h1);

        // Zero data still updates the one-hot record.
        drive(1'b1, 2'b01, 8'h00);
        step();
        check_eq("zero_outs", outs(), 32'h0);
        check_eq("zero_onehot", {28'h0, sel_onehot}, 32'h2);

        // Asynchronous reset mid-cycle with out1 = 1.
        drive(1'b1, 2'b01, 8'h01);
        step();
        check_eq("pre_rst_out1", outs(), 32'h0000_0100);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_outs", outs(), 32'h0);
        check_eq("async_rst_onehot", {28'h0, sel_onehot}, 32'h0);
        step();
        check_eq("rst_held_outs", outs(), 32'h0);
        check_eq("rst_held_onehot", {28'h0, sel_onehot}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset release performs a normal update.
        drive(1'b1, 2'b10, 8'h5A);
        step();
        check_eq("post_rst_out2", outs(), 32'h005A_0000);

`ifdef DEMUX_ROUTE_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("cnt_rst", {24'h0, cnt3, cnt2, cnt1, cnt0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic [CNT_W-1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 2'b10, 8'h11);
                step();
                check_eq($sformatf("cnt2_%0d", i), {30'h0, cnt2}, {30'h0, exp_seq[i]});
                check_eq($sformatf("cnt_others_%0d", i), {26'h0, cnt3, cnt1, cnt0}, 32'h0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("cnt_rst_clear", {24'h0, cnt3, cnt2, cnt1, cnt0}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
